ldl_ring_shift: RTL and testbench
=================================

LDL_RING_SHIFT -- requirements
Module: ldl_ring_shift

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits; legal range WIDTH >= 2, any integer (not only powers of two).
REQ-002 Derived constant SW = $clog2(WIDTH), width of the step port.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_vld  input  1  qualifies dir/step/x in the current cycle.
REQ-006 dir  input  1  rotation direction: 0 = rotate left (toward MSB), 1 = rotate right (toward LSB).
REQ-007 step  input  SW  rotation amount in bit positions.
REQ-008 x  input  WIDTH  data to rotate.
REQ-009 out_vld  output  1  y holds a valid result this cycle.
REQ-010 y  output  WIDTH  rotated data, registered.

Function
REQ-011 Rotate left by s SHALL give y[(i+s) mod WIDTH] = x[i] for every i; rotate right SHALL give y[i] = x[(i+s) mod WIDTH].
REQ-012 The rotation SHALL be lossless: no bit is dropped or zero-filled, and popcount(y) = popcount(x).
REQ-013 The effective amount SHALL be step mod WIDTH; for non-power-of-two WIDTH, step >= WIDTH wraps (e.g. WIDTH=6, step=7 equals step=1).
REQ-014 step = 0 SHALL pass x unchanged for either dir.
REQ-015 The datapath SHALL be a logarithmic barrel: stage k rotates by 2^k when step[k] = 1 and passes through otherwise, for k = 0..SW-1.
REQ-016 Latency (macro absent) SHALL be 1 cycle: a sample with in_vld = 1 at edge n appears on y with out_vld = 1 after edge n.
REQ-017 out_vld SHALL be in_vld delayed by the pipeline latency, with no backpressure; a new sample is accepted every cycle.
REQ-018 y SHALL update only when a valid sample reaches the output register and SHALL hold its last value while out_vld = 0.
REQ-019 Back-to-back valid samples with changing dir/step SHALL each produce their own correct result in order, with no bubbles.

Reset
REQ-020 While rst = 1, y SHALL be 0 and out_vld SHALL be 0 immediately, independent of clk.
REQ-021 Samples in flight when rst asserts SHALL be discarded; after rst deasserts, the first out_vld SHALL correspond to the first in_vld sampled after deassertion.

Configuration
REQ-022 Macro LDL_RING_SHIFT_PIPE_EN SHALL, when defined, insert one extra register (data, remaining step bits, dir, valid) after stage floor(SW/2), giving latency 2.
REQ-023 Without LDL_RING_SHIFT_PIPE_EN, latency SHALL be exactly 1 and the function SHALL be identical in both builds apart from latency.
REQ-024 The extra pipeline register SHALL reset to 0 under rst exactly as the output register does.

Structure
REQ-025 Package ldl_ring_shift_pkg SHALL hold the direction encoding constants (DIR_LEFT = 0, DIR_RIGHT = 1) and the rotate-by-constant helper function.
REQ-026 One sub-module, ldl_ring_shift_stage (parameters WIDTH and AMT), SHALL implement one conditional rotate-by-AMT stage; the top SHALL instantiate it SW times via generate.

Verification (WIDTH = 8 unless stated)
REQ-027 x=A5, dir=0, step=0..7 in consecutive cycles -> y = A5,4B,96,2D,5A,B4,69,D2 one cycle after each sample, out_vld high throughout.
REQ-028 x=A5, dir=1, step=1 -> D2; step=4 -> 5A; step=7 -> 4B.
REQ-029 rst pulsed mid-stream with in_vld held high -> y=00 and out_vld=0 at once; first result is for the first sample after release.
REQ-030 in_vld toggling 1,0,1 -> out_vld 1,0,1 one cycle later; y holds its value during the gap.
REQ-031 WIDTH=6, x=6'b000001, dir=0, step=7 -> 6'b000010 (step wraps modulo WIDTH).
REQ-032 Build with LDL_RING_SHIFT_PIPE_EN; repeat REQ-027 -> same values, each appearing 2 cycles after its sample.

Source files
------------

// File: rtl/ldl_ring_shift_pkg.sv
// ldl_ring_shift_pkg: direction encoding and the rotate-by-constant bit mapping
package ldl_ring_shift_pkg;
  localparam logic DIR_LEFT = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  // Output bit i of a width-w rotation by amt takes this input bit.
  function automatic int src_idx(input int i, input int w, input int amt, input logic dir);
    int s;
    s = amt % w;
    return (dir == DIR_RIGHT) ? (i + s) % w : (i + w - s) % w;
  endfunction
endpackage

// File: rtl/ldl_ring_shift_if.sv
// ldl_ring_shift_if: sample-in / result-out bundle for the ring shifter
interface ldl_ring_shift_if #(parameter int WIDTH = 8);
  localparam int SW = $clog2(WIDTH);
  logic in_vld;
  logic dir;
  logic [SW-1:0] step;
  logic [WIDTH-1:0] x;
  logic out_vld;
  logic [WIDTH-1:0] y;
  modport master(output in_vld, dir, step, x, input out_vld, y);
  modport slave(input in_vld, dir, step, x, output out_vld, y);
endinterface

// File: rtl/ldl_ring_shift_stage.sv
// ldl_ring_shift_stage: one conditional rotate-by-AMT barrel stage
module ldl_ring_shift_stage
  import ldl_ring_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT = 1
) (
  input logic en,
  input logic dir,
  input logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] l, r;
  for (genvar i = 0; i < WIDTH; i++) begin : g_b
    localparam int LI = src_idx(i, WIDTH, AMT, DIR_LEFT);
    localparam int RI = src_idx(i, WIDTH, AMT, DIR_RIGHT);
    assign l[i] = d[LI];
    assign r[i] = d[RI];
  end
  assign q = en ? ((dir == DIR_RIGHT) ? r : l) : d;
endmodule

// File: rtl/ldl_ring_shift.sv
// ldl_ring_shift: registered logarithmic barrel rotator, amount taken modulo WIDTH.
// Define LDL_RING_SHIFT_PIPE_EN to add a mid-barrel register (latency 2).
module ldl_ring_shift #(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst,
  ldl_ring_shift_if.slave s
);
  localparam int SW = $clog2(WIDTH);
  logic [WIDTH-1:0] dn [SW+1];
  logic vl;
  assign dn[0] = s.x;
`ifdef LDL_RING_SHIFT_PIPE_EN
  localparam int P = SW / 2;
  logic [WIDTH-1:0] p_d;
  logic [SW-1:0] p_s;
  logic p_dr, p_v;
  assign vl = p_v;
`else
  assign vl = s.in_vld;
`endif
  // Rotating by 2^k in a ring is already modulo WIDTH, so stages sum to step mod WIDTH.
  for (genvar k = 0; k < SW; k++) begin : g_st
    logic [WIDTH-1:0] q;
    logic en, dr;
`ifdef LDL_RING_SHIFT_PIPE_EN
    assign en = (k > P) ? p_s[k] : s.step[k];
    assign dr = (k > P) ? p_dr : s.dir;
    assign dn[k+1] = (k == P) ? p_d : q;
`else
    assign en = s.step[k];
    assign dr = s.dir;
    assign dn[k+1] = q;
`endif
    ldl_ring_shift_stage #(.WIDTH(WIDTH), .AMT(1 << k)) u_stage (
      .en(en),
      .dir(dr),
      .d(dn[k]),
      .q(q)
    );
  end
`ifdef LDL_RING_SHIFT_PIPE_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      p_d <= '0;
      p_s <= '0;
      p_dr <= 1'b0;
      p_v <= 1'b0;
    end else begin
      p_d <= g_st[P].q;
      p_s <= s.step;
      p_dr <= s.dir;
      p_v <= s.in_vld;
    end
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s.out_vld <= 1'b0;
      s.y <= '0;
    end else begin
      s.out_vld <= vl;
      if (vl) s.y <= dn[SW];
    end
endmodule

// File: tb/tb_ldl_ring_shift.sv
// tb_ldl_ring_shift: scoreboard bench for WIDTH=8 and WIDTH=6 rotators
module tb_ldl_ring_shift;
  import ldl_ring_shift_pkg::*;
`ifdef LDL_RING_SHIFT_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  typedef struct {
    logic [7:0] y;
    int due;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  exp_t q8[$];
  exp_t q6[$];
  logic [7:0] last8 = '0;
  logic [5:0] last6 = '0;
  ldl_ring_shift_if #(.WIDTH(8)) b8();
  ldl_ring_shift_if #(.WIDTH(6)) b6();
  ldl_ring_shift #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .s(b8));
  ldl_ring_shift #(.WIDTH(6)) dut6 (.clk(clk), .rst(rst), .s(b6));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", n, a, e, $time);
    end
  endtask
  // Reference rotation straight from the index rule y[(i+s)%w]=x[i] / y[i]=x[(i+s)%w].
  function automatic logic [7:0] rot(input logic [7:0] v, input int w, input logic d, input int st);
    logic [7:0] r;
    int s;
    r = '0;
    s = st % w;
    for (int i = 0; i < w; i++)
      if (d == DIR_LEFT) r[(i + s) % w] = v[i];
      else r[i] = v[(i + s) % w];
    return r;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
    b8.in_vld = 1'b0;
    b6.in_vld = 1'b0;
  endtask
  task automatic put8(input logic d, input logic [2:0] st, input logic [7:0] xv, input logic [7:0] ev);
    b8.in_vld = 1'b1;
    b8.dir = d;
    b8.step = st;
    b8.x = xv;
    q8.push_back('{ev, cyc + LAT});
  endtask
  task automatic put6(input logic d, input logic [2:0] st, input logic [5:0] xv, input logic [5:0] ev);
    b6.in_vld = 1'b1;
    b6.dir = d;
    b6.step = st;
    b6.x = xv;
    q6.push_back('{{2'b00, ev}, cyc + LAT});
  endtask
  always @(negedge clk)
    if (!rst) begin
      if (b8.out_vld) begin
        if (q8.size() == 0) chk("w8_unexpected_vld", 32'(b8.y), 32'hdead);
        else begin
          exp_t e;
          e = q8.pop_front();
          chk("w8_y", 32'(b8.y), 32'(e.y));
          chk("w8_latency", cyc, e.due);
          last8 = b8.y;
        end
      end else chk("w8_hold", 32'(b8.y), 32'(last8));
      if (b6.out_vld) begin
        if (q6.size() == 0) chk("w6_unexpected_vld", 32'(b6.y), 32'hdead);
        else begin
          exp_t e;
          e = q6.pop_front();
          chk("w6_y", 32'(b6.y), 32'(e.y));
          chk("w6_latency", cyc, e.due);
          last6 = b6.y;
        end
      end else chk("w6_hold", 32'(b6.y), 32'(last6));
    end
  initial begin
    logic [7:0] tbl [8];
    logic [7:0] xv;
    logic [2:0] st;
    logic d;
    tbl = '{8'hA5, 8'h4B, 8'h96, 8'h2D, 8'h5A, 8'hB4, 8'h69, 8'hD2};
    b8.in_vld = 1'b0; b8.dir = 1'b0; b8.step = '0; b8.x = '0;
    b6.in_vld = 1'b0; b6.dir = 1'b0; b6.step = '0; b6.x = '0;
    #1;
    chk("reset_y8", 32'(b8.y), 0);
    chk("reset_vld8", 32'(b8.out_vld), 0);
    chk("reset_y6", 32'(b6.y), 0);
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      put8(DIR_LEFT, 3'(i), 8'hA5, tbl[i]);
    end
    tick(); put8(DIR_RIGHT, 3'd1, 8'hA5, 8'hD2);
    tick(); put8(DIR_RIGHT, 3'd4, 8'hA5, 8'h5A);
    tick(); put8(DIR_RIGHT, 3'd7, 8'hA5, 8'h4B);
    put6(DIR_LEFT, 3'd7, 6'b000001, 6'b000010);
    tick(); put6(DIR_LEFT, 3'd6, 6'b000001, 6'b000001);
    tick(); put6(DIR_RIGHT, 3'd7, 6'b000001, 6'b100000);
    tick(); put8(DIR_LEFT, 3'd3, 8'h81, 8'h0C);
    tick();
    tick(); put8(DIR_RIGHT, 3'd2, 8'h81, 8'h60);
    repeat (4) tick();
    for (int i = 0; i < 300; i++) begin
      tick();
      if ($urandom_range(0, 3) != 0) begin
        xv = 8'($urandom); st = 3'($urandom); d = 1'($urandom);
        put8(d, st, xv, rot(xv, 8, d, int'(st)));
      end
      if ($urandom_range(0, 3) != 0) begin
        xv = 8'($urandom); st = 3'($urandom); d = 1'($urandom);
        put6(d, st, xv[5:0], rot({2'b00, xv[5:0]}, 6, d, int'(st)));
      end
      if (i == 150) begin
        #2;
        rst = 1'b1;
        b8.in_vld = 1'b1;
        b8.x = 8'hFF;
        b6.in_vld = 1'b1;
        #1;
        chk("midrst_y8", 32'(b8.y), 0);
        chk("midrst_vld8", 32'(b8.out_vld), 0);
        chk("midrst_y6", 32'(b6.y), 0);
        chk("midrst_vld6", 32'(b6.out_vld), 0);
        q8.delete();
        q6.delete();
        last8 = '0;
        last6 = '0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        put8(DIR_LEFT, 3'd1, 8'hA5, 8'h4B);
        put6(DIR_LEFT, 3'd7, 6'b000001, 6'b000010);
      end
    end
    tick();
    for (int i = 0; i < 20 && (q8.size() != 0 || q6.size() != 0); i++) tick();
    chk("w8_drained", q8.size(), 0);
    chk("w6_drained", q6.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
